// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over WIDTH+1 bit
// extended operands, giving an exact product for signed and unsigned operations.
module booth_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic signed [E-1:0]  acc, q, m;
    logic                 qm1;
    logic [CW-1:0]        cnt;
    logic                 last_step;

    // One extra bit lets unsigned operands ride the signed Booth datapath unchanged.
    function automatic logic signed [E-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
        return $signed({sgn & v[WIDTH-1], v});
    endfunction

    // Add/subtract the multiplicand, then arithmetic-shift {acc,q,q_-1} right by one.
    function automatic logic [2*E:0] booth_step(input logic signed [E-1:0] acc_in,
                                                 input logic signed [E-1:0] q_in,
                                                 input logic signed [E-1:0] m_in,
                                                 input logic qm1_in);
        logic signed [E-1:0] sum;
        case ({q_in[0], qm1_in})
            2'b10:   sum = acc_in - m_in;
            2'b01:   sum = acc_in + m_in;
            default: sum = acc_in;
        endcase
        return {sum[E-1], sum, q_in};
    endfunction

    assign last_step = (cnt == CW'(E - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state == CALC) busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) cnt <= '0;
                CALC: cnt <= cnt + CW'(1);
                DONE: begin
                    product <= {acc[WIDTH-2:0], q};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                q   <= extend(a, tc);
                m   <= extend(b, tc);
                acc <= '0;
                qm1 <= 1'b0;
            end
            CALC: {acc, q, qm1} <= booth_step(acc, q, m, qm1);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and exhaustive (WIDTH=4) checks of booth_seq_mult: products, latency,
// busy/done framing, ignored starts, mid-operation reset and back-to-back operation.
module tb_booth_seq_mult;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           tc;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .tc(tc), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    // One operation; k counts clock edges after the accepting edge, sampled on negedges.
    task automatic do_op(input logic t, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [2*W-1:0] p, output int lat, output int bcnt, output int dcnt);
        @(negedge clk);
        tc = t; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        lat = -1; bcnt = 0; dcnt = 0; p = 'x;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = k; p = product; end
            end
            if (k < 9) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tc = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b product=%h required 0 0 00", busy, done, product);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [2*W-1:0] p;
        int lat, bcnt, dcnt;
        logic        vt [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  va [8] = '{4'h3, 4'h8, 4'hF, 4'hF, 4'h0, 4'h7, 4'h8, 4'h8};
        logic [3:0]  vb [8] = '{4'h8, 4'h8, 4'hF, 4'hF, 4'hF, 4'h8, 4'h8, 4'h7};
        logic [7:0]  vp [8] = '{8'hE8, 8'h40, 8'hE1, 8'h01, 8'h00, 8'hC8, 8'h40, 8'hC8};
        for (int i = 0; i < 8; i++) begin
            do_op(vt[i], va[i], vb[i], p, lat, bcnt, dcnt);
            total++;
            if (p !== vp[i]) begin
                bad++;
                $display("FAIL directed_%0d product: got %h required %h", i, p, vp[i]);
            end
            total++;
            if (lat != W + 2 || bcnt != W + 1 || dcnt != 1) begin
                bad++;
                $display("FAIL directed_%0d timing: lat=%0d busy=%0d dones=%0d required %0d %0d 1",
                         i, lat, bcnt, dcnt, W + 2, W + 1);
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [2*W-1:0] p, exp;
        int lat, bcnt, dcnt, errs;
        errs = 0;
        for (int t = 0; t < 2; t++)
            for (int ai = 0; ai < 16; ai++)
                for (int bi = 0; bi < 16; bi++) begin
                    logic [W-1:0] av, bv;
                    av = W'(ai); bv = W'(bi);
                    if (t == 1) exp = 8'(int'($signed(av)) * int'($signed(bv)));
                    else        exp = 8'(ai * bi);
                    do_op(t[0], av, bv, p, lat, bcnt, dcnt);
                    total++;
                    if (p !== exp || lat != W + 2 || bcnt != W + 1 || dcnt != 1) begin
                        bad++;
                        if (errs++ < 10)
                            $display("FAIL exhaustive tc=%0d a=%h b=%h: got %h lat=%0d busy=%0d dones=%0d required %h %0d %0d 1",
                                     t, av, bv, p, lat, bcnt, dcnt, exp, W + 2, W + 1);
                    end
                end
    endtask

    task automatic test_ignored_start;
        int dcnt, lat;
        logic [2*W-1:0] p;
        @(negedge clk);
        tc = 1'b1; a = 4'h3; b = 4'h8; start = 1'b1;
        @(posedge clk);
        dcnt = 0; lat = -1; p = '0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 2 || k == 5) begin start = 1'b1; a = 4'h7; b = 4'h7; end
            if (k == 3 || k == 6) start = 1'b0;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = k; p = product; end
            end
            @(negedge clk);
        end
        total++;
        if (p !== 8'hE8 || lat != W + 2 || dcnt != 1) begin
            bad++;
            $display("FAIL ignored_start: product=%h lat=%0d dones=%0d required E8 %0d 1", p, lat, dcnt, W + 2);
        end
    endtask

    task automatic test_mid_reset;
        logic [2*W-1:0] p;
        int lat, bcnt, dcnt;
        @(negedge clk);
        tc = 1'b0; a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b product=%h required 0 0 00", busy, done, product);
        end
        rst = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_done: done=%b required 0", done);
            end
        end
        do_op(1'b1, 4'h5, 4'hD, p, lat, bcnt, dcnt);
        total++;
        if (p !== 8'hF1 || lat != W + 2 || dcnt != 1) begin
            bad++;
            $display("FAIL post_reset_op: product=%h lat=%0d dones=%0d required F1 %0d 1", p, lat, dcnt, W + 2);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int at [3];
        logic [2*W-1:0] got [3];
        logic [2*W-1:0] exp [3] = '{8'h15, 8'hF4, 8'h38};
        n = 0;
        @(negedge clk);
        tc = 1'b1; a = 4'h7; b = 4'h3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 26; k++) begin
            if (k == 1)  begin tc = 1'b1; a = 4'hA; b = 4'h2; end
            if (k == 8)  begin tc = 1'b0; a = 4'h8; b = 4'h7; end
            if (k == 15) start = 1'b0;
            if (done) begin
                if (n < 3) begin at[n] = k; got[n] = product; end
                n++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL back_to_back_count: dones=%0d required 3", n);
        end
        for (int i = 0; i < 3 && i < n; i++) begin
            total++;
            if (got[i] !== exp[i] || at[i] != (W + 2) + i * (W + 3)) begin
                bad++;
                $display("FAIL back_to_back_%0d: product=%h at=%0d required %h at %0d",
                         i, got[i], at[i], exp[i], (W + 2) + i * (W + 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
